ocupacion_estacionamiento: RTL and testbench
============================================

# ocupacion_estacionamiento

Parametrised parking-occupancy counter, successor to the 3-bit entry/exit car counter. It derives entry and exit events from two photo-beam sensors, A on the street side and B on the lot side, using a direction-detecting state machine. It keeps a saturating occupancy count up to a configurable capacity, and raises full, empty, near-full and sticky error flags for the barrier and display logic.

## Interface
- CAPACIDAD, 7: maximum cars; count range 0..CAPACIDAD; must be ≥ 1
- W, $clog2(CAPACIDAD+1): count width; derived, never overridden
- UMBRAL, CAPACIDAD-1: casi_lleno asserts when autos ≥ UMBRAL
- SYNC_STAGES, 2: synchroniser depth on sensor inputs, ≥ 2
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- sensor_a  input  1  street-side beam, 1 = interrupted; asynchronous
- sensor_b  input  1  lot-side beam, 1 = interrupted; asynchronous
- borrar  input  1  synchronous clear of count and error flags
- autos  output  W  current occupancy, registered
- evt_entrada  output  1  one-cycle pulse, entry committed
- evt_salida  output  1  one-cycle pulse, exit committed
- lleno  output  1  autos == CAPACIDAD
- vacio  output  1  autos == 0
- casi_lleno  output  1  autos ≥ UMBRAL
- err_lleno  output  1  sticky: entry completed while full
- err_vacio  output  1  sticky: exit completed while empty

## Operation
- Sensors pass through SYNC_STAGES flops; the FSM sees only the synchronised pair {a,b}.
- FSM states: IDLE, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_AB, SAL_A, ESPERA.
- Entry sequence is 00→10→11→01→00:
  - IDLE + 10 → ENT_A; ENT_A + 11 → ENT_AB; ENT_AB + 01 → ENT_B.
  - ENT_B + 00 → IDLE and commits an entry.
- Exit sequence mirrors entry, 00→01→11→10→00:
  - IDLE + 01 → SAL_B; SAL_B + 11 → SAL_AB; SAL_AB + 10 → SAL_A.
  - SAL_A + 00 → IDLE and commits an exit.
- Back-step of one stage is allowed and takes the previous state: ENT_AB + 10 → ENT_A, ENT_B + 11 → ENT_AB, and the exit equivalents. This covers a car rocking in the gate.
- Unchanged input holds the current state.
- 00 in any non-final state → IDLE with no count change (car backed out).
- Any other transition (e.g. ENT_A + 01, or IDLE + 11) → ESPERA, which stays until 00, then → IDLE with no count change.
- Committed entry:
  - autos < CAPACIDAD: autos+1, evt_entrada pulses.
  - otherwise autos unchanged, err_lleno set, evt_entrada still pulses.
- Committed exit:
  - autos > 0: autos−1, evt_salida pulses.
  - otherwise autos unchanged, err_vacio set, evt_salida still pulses.
- Count arithmetic is unsigned W-bit and never wraps.
- borrar: autos ← 0, err_lleno ← 0, err_vacio ← 0. The FSM is not affected. borrar wins over a commit in the same cycle; the event pulse still fires but the count and errors are cleared.
- Reset values: autos 0, both evt 0, both err 0, FSM IDLE, synchroniser flops 0. Hence vacio=1, lleno=0, and casi_lleno = (UMBRAL==0).
- Reset mid-sequence abandons it; no event is produced afterwards for that car.

## Timing
- Raw sensor change reaches the FSM input after SYNC_STAGES edges.
- The commit is decided combinationally on the edge where the FSM sees the final 00. autos, evt_* and err_* update on that same edge.
- Latency from the raw final 00 to the autos update is SYNC_STAGES+1 edges.
- lleno, vacio and casi_lleno are decoded combinationally from the autos register, so they have zero latency from autos.
- evt_* is high exactly one cycle per commit. Minimum spacing between commits is 4 FSM cycles.
- borrar takes effect on the next rising edge.

## Structure
- Package ocupacion_pkg holds the FSM state encoding localparams (3-bit) and the sensor-pair constants S_NINGUNO=00, S_A=10, S_AB=11, S_B=01.
- Sub-module sincronizador holds the SYNC_STAGES-deep flop chain, instantiated once per sensor, with async reset to 0.
- Top level holds the FSM, the count register and the flag logic.

## Test plan
- Reset, then idle 10 cycles → autos=0, vacio=1, lleno=0, all pulses/errors 0.
- 8 clean entry sequences with CAPACIDAD=7 → autos steps 1..7; lleno=1 after the 7th; the 8th gives evt_entrada and sets err_lleno with autos held at 7; casi_lleno from autos=6.
- Exit sequence at autos=0 → evt_salida pulse, err_vacio=1, autos stays 0; then borrar → both errors 0.
- Aborted entry 00→10→11→10→00 and illegal 00→10→01→11→00 → no event, FSM back to IDLE, autos unchanged.
- Entry with rocking 10→11→10→11→01→00 → exactly one evt_entrada, autos+1, arriving SYNC_STAGES+1 edges after the final raw 00.
- Reset asserted while in ENT_AB, released, then sensors go 01→00 → ESPERA path, no entry counted, autos=0.

Source files
------------

// File: rtl/ocupacion_pkg.sv
// Shared encodings for the parking-occupancy counter: FSM states and sensor-pair codes {a,b}.
package ocupacion_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENT_A  = 3'd1,
        ENT_AB = 3'd2,
        ENT_B  = 3'd3,
        SAL_B  = 3'd4,
        SAL_AB = 3'd5,
        SAL_A  = 3'd6,
        ESPERA = 3'd7
    } estado_t;

    localparam logic [1:0] S_NINGUNO = 2'b00;
    localparam logic [1:0] S_A       = 2'b10;
    localparam logic [1:0] S_AB      = 2'b11;
    localparam logic [1:0] S_B       = 2'b01;

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchroniser for one asynchronous sensor bit; latency SYNC_STAGES edges, no backpressure.
module sincronizador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dat,
    output logic o_dat
);

    logic [SYNC_STAGES-1:0] r_cadena;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cadena <= '0;
        else     r_cadena <= {r_cadena[SYNC_STAGES-2:0], i_dat};
    end

    assign o_dat = r_cadena[SYNC_STAGES-1];

endmodule

// File: rtl/ocupacion_estacionamiento.sv
// Two-beam direction FSM driving a saturating occupancy counter with status flags.
// Commit lands SYNC_STAGES+1 edges after the raw final 00; flags decode the count with no extra delay.
module ocupacion_estacionamiento
    import ocupacion_pkg::*;
#(
    parameter int CAPACIDAD   = 7,
    parameter int W           = $clog2(CAPACIDAD + 1),
    parameter int UMBRAL      = CAPACIDAD - 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sensor_a,
    input  logic         sensor_b,
    input  logic         borrar,
    output logic [W-1:0] autos,
    output logic         evt_entrada,
    output logic         evt_salida,
    output logic         lleno,
    output logic         vacio,
    output logic         casi_lleno,
    output logic         err_lleno,
    output logic         err_vacio
);

    localparam logic [W-1:0] CAP_W    = W'(CAPACIDAD);
    localparam logic [W-1:0] UMBRAL_W = W'(UMBRAL);

    logic         w_a, w_b;
    logic [1:0]   w_par;
    estado_t      r_estado, w_sig;
    logic         w_ent, w_sal;
    logic [W-1:0] r_autos;
    logic         r_evt_ent, r_evt_sal, r_err_lleno, r_err_vacio;

    sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc_a (
        .clk(clk), .rst(rst), .i_dat(sensor_a), .o_dat(w_a)
    );
    sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc_b (
        .clk(clk), .rst(rst), .i_dat(sensor_b), .o_dat(w_b)
    );

    assign w_par = {w_a, w_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_estado <= IDLE;
        else     r_estado <= w_sig;
    end

    // 00 always returns to IDLE; only the final stage of each direction commits.
    always_comb begin
        w_sig = r_estado;
        w_ent = 1'b0;
        w_sal = 1'b0;
        if (w_par == S_NINGUNO) begin
            w_sig = IDLE;
            w_ent = (r_estado == ENT_B);
            w_sal = (r_estado == SAL_A);
        end else begin
            case (r_estado)
                IDLE:    w_sig = (w_par == S_A) ? ENT_A : (w_par == S_B) ? SAL_B : ESPERA;
                ENT_A:   w_sig = (w_par == S_A) ? ENT_A : (w_par == S_AB) ? ENT_AB : ESPERA;
                ENT_AB:  w_sig = (w_par == S_AB) ? ENT_AB : (w_par == S_B) ? ENT_B : ENT_A;
                ENT_B:   w_sig = (w_par == S_B) ? ENT_B : (w_par == S_AB) ? ENT_AB : ESPERA;
                SAL_B:   w_sig = (w_par == S_B) ? SAL_B : (w_par == S_AB) ? SAL_AB : ESPERA;
                SAL_AB:  w_sig = (w_par == S_AB) ? SAL_AB : (w_par == S_A) ? SAL_A : SAL_B;
                SAL_A:   w_sig = (w_par == S_A) ? SAL_A : (w_par == S_AB) ? SAL_AB : ESPERA;
                default: w_sig = ESPERA;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_autos     <= '0;
            r_evt_ent   <= 1'b0;
            r_evt_sal   <= 1'b0;
            r_err_lleno <= 1'b0;
            r_err_vacio <= 1'b0;
        end else begin
            r_evt_ent <= w_ent;
            r_evt_sal <= w_sal;
            // Clearing outranks a simultaneous commit; the pulse still reports the car.
            if (borrar) begin
                r_autos     <= '0;
                r_err_lleno <= 1'b0;
                r_err_vacio <= 1'b0;
            end else if (w_ent) begin
                if (r_autos < CAP_W) r_autos <= r_autos + 1'b1;
                else                 r_err_lleno <= 1'b1;
            end else if (w_sal) begin
                if (r_autos != '0) r_autos <= r_autos - 1'b1;
                else               r_err_vacio <= 1'b1;
            end
        end
    end

    assign autos       = r_autos;
    assign evt_entrada = r_evt_ent;
    assign evt_salida  = r_evt_sal;
    assign err_lleno   = r_err_lleno;
    assign err_vacio   = r_err_vacio;
    assign lleno       = (r_autos == CAP_W);
    assign vacio       = (r_autos == '0);
    assign casi_lleno  = (r_autos >= UMBRAL_W);

endmodule

// File: tb/tb_ocupacion_estacionamiento.sv
// Directed bench for ocupacion_estacionamiento with default parameters (capacity 7, threshold 6, 2 sync stages).
module tb_ocupacion_estacionamiento;
    import ocupacion_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_a = 1'b0;
    logic       sensor_b = 1'b0;
    logic       borrar = 1'b0;
    logic [2:0] autos;
    logic       evt_entrada, evt_salida, lleno, vacio, casi_lleno, err_lleno, err_vacio;

    int n_chk = 0;
    int n_ok  = 0;
    int n_ent = 0;
    int n_sal = 0;

    ocupacion_estacionamiento dut (
        .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b), .borrar(borrar),
        .autos(autos), .evt_entrada(evt_entrada), .evt_salida(evt_salida),
        .lleno(lleno), .vacio(vacio), .casi_lleno(casi_lleno),
        .err_lleno(err_lleno), .err_vacio(err_vacio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (evt_entrada) n_ent++;
        if (evt_salida)  n_sal++;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_chk++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
    endtask

    // Present a sensor pair and hold it long enough for the FSM to settle.
    task automatic paso(input logic a, input logic b);
        sensor_a = a;
        sensor_b = b;
        repeat (4) @(negedge clk);
    endtask

    // Drive the final 00 and check the commit lands exactly SYNC_STAGES+1 edges later.
    task automatic cierre(input string tag, input logic e_ent, input logic e_sal,
                          input int e_autos_antes, input int e_autos);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (2) @(negedge clk);
        comprobar({tag, "_pre_evt"}, {31'd0, evt_entrada | evt_salida}, 32'd0);
        comprobar({tag, "_pre_autos"}, 32'(autos), 32'(e_autos_antes));
        @(negedge clk);
        comprobar({tag, "_evt_ent"}, {31'd0, evt_entrada}, {31'd0, e_ent});
        comprobar({tag, "_evt_sal"}, {31'd0, evt_salida}, {31'd0, e_sal});
        comprobar({tag, "_autos"}, 32'(autos), 32'(e_autos));
        @(negedge clk);
        comprobar({tag, "_evt_fin"}, {31'd0, evt_entrada | evt_salida}, 32'd0);
    endtask

    task automatic entrada(input string tag, input int antes, input int despues);
        paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        paso(1'b0, 1'b1);
        cierre(tag, 1'b1, 1'b0, antes, despues);
    endtask

    initial begin
        int base_ent, base_sal, esp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        comprobar("rst_autos", 32'(autos), 32'd0);
        comprobar("rst_vacio", {31'd0, vacio}, 32'd1);
        comprobar("rst_lleno", {31'd0, lleno}, 32'd0);
        comprobar("rst_casi", {31'd0, casi_lleno}, 32'd0);
        comprobar("rst_evt", {30'd0, evt_entrada, evt_salida}, 32'd0);
        comprobar("rst_err", {30'd0, err_lleno, err_vacio}, 32'd0);

        // Fill to capacity, then one more entry overflows.
        for (int i = 0; i < 8; i++) begin
            esp = (i + 1 > 7) ? 7 : i + 1;
            entrada($sformatf("ent%0d", i + 1), (i > 7) ? 7 : i, esp);
            comprobar($sformatf("ent%0d_lleno", i + 1), {31'd0, lleno}, (esp == 7) ? 32'd1 : 32'd0);
            comprobar($sformatf("ent%0d_casi", i + 1), {31'd0, casi_lleno}, (esp >= 6) ? 32'd1 : 32'd0);
            comprobar($sformatf("ent%0d_errl", i + 1), {31'd0, err_lleno}, (i == 7) ? 32'd1 : 32'd0);
            comprobar($sformatf("ent%0d_vacio", i + 1), {31'd0, vacio}, 32'd0);
        end

        borrar = 1'b1;
        @(negedge clk);
        borrar = 1'b0;
        comprobar("borrar1_autos", 32'(autos), 32'd0);
        comprobar("borrar1_errl", {31'd0, err_lleno}, 32'd0);
        comprobar("borrar1_vacio", {31'd0, vacio}, 32'd1);

        // Exit from an empty lot.
        paso(1'b0, 1'b1);
        paso(1'b1, 1'b1);
        paso(1'b1, 1'b0);
        cierre("sal_vacio", 1'b0, 1'b1, 0, 0);
        comprobar("sal_vacio_errv", {31'd0, err_vacio}, 32'd1);
        borrar = 1'b1;
        @(negedge clk);
        borrar = 1'b0;
        comprobar("borrar2_err", {30'd0, err_lleno, err_vacio}, 32'd0);

        // Normal exit after one entry.
        entrada("ent_pre_sal", 0, 1);
        paso(1'b0, 1'b1);
        paso(1'b1, 1'b1);
        paso(1'b1, 1'b0);
        cierre("sal_ok", 1'b0, 1'b1, 1, 0);
        comprobar("sal_ok_errv", {31'd0, err_vacio}, 32'd0);

        // Aborted entry and illegal sequence must not count.
        base_ent = n_ent;
        base_sal = n_sal;
        paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        paso(1'b1, 1'b0);
        paso(1'b0, 1'b0);
        comprobar("abort_estado", 32'(dut.r_estado), 32'(IDLE));
        paso(1'b1, 1'b0);
        paso(1'b0, 1'b1);
        comprobar("ilegal_espera", 32'(dut.r_estado), 32'(ESPERA));
        paso(1'b1, 1'b1);
        paso(1'b0, 1'b0);
        comprobar("ilegal_estado", 32'(dut.r_estado), 32'(IDLE));
        comprobar("abort_eventos", 32'(n_ent - base_ent + n_sal - base_sal), 32'd0);
        comprobar("abort_autos", 32'(autos), 32'd0);

        // Rocking car counts once.
        base_ent = n_ent;
        paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        paso(1'b0, 1'b1);
        cierre("vaiven", 1'b1, 1'b0, 0, 1);
        repeat (4) @(negedge clk);
        comprobar("vaiven_n_ent", 32'(n_ent - base_ent), 32'd1);

        // Reset in ENT_AB abandons the car.
        paso(1'b1, 1'b0);
        paso(1'b1, 1'b1);
        comprobar("mid_ent_ab", 32'(dut.r_estado), 32'(ENT_AB));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        comprobar("mid_rst_autos", 32'(autos), 32'd0);
        rst = 1'b0;
        base_ent = n_ent;
        repeat (4) @(negedge clk);
        comprobar("mid_espera", 32'(dut.r_estado), 32'(ESPERA));
        paso(1'b0, 1'b1);
        paso(1'b0, 1'b0);
        comprobar("mid_idle", 32'(dut.r_estado), 32'(IDLE));
        comprobar("mid_n_ent", 32'(n_ent - base_ent), 32'd0);
        comprobar("mid_autos", 32'(autos), 32'd0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
